// File: rtl/dac_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dac_pkg
//  Description : Shared constants for the 32-bit DAC SPI frame
//                {8'h80, command[3:0], address[3:0], data[11:0], 4'h1}.
//                Used by both the responder and the master side.
//  Contents    : frame/channel sizes, command codes, broadcast address,
//                field bit positions, field typedef and decode helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package dac_pkg;

    // Frame geometry
    localparam int WIDTH = 32;
    localparam int DW    = 12;
    localparam int NCH   = 4;

    // Command codes
    localparam logic [3:0] CMD_WR        = 4'h0;
    localparam logic [3:0] CMD_UPD       = 4'h1;
    localparam logic [3:0] CMD_WR_UPDALL = 4'h2;
    localparam logic [3:0] CMD_WR_UPD    = 4'h3;
    localparam logic [3:0] CMD_NOP       = 4'hF;

    // Address that applies a command to every channel
    localparam logic [3:0] ADDR_ALL = 4'hF;

    // Fixed header/trailer sent by the master; the responder ignores them
    localparam logic [7:0] FRAME_HDR = 8'h80;
    localparam logic [3:0] FRAME_TRL = 4'h1;

    // Field positions inside the 32-bit frame
    localparam int CMD_LSB  = 20;
    localparam int ADDR_LSB = 16;
    localparam int DATA_LSB = 4;

    typedef struct packed {
        logic [3:0]    cmd;
        logic [3:0]    addr;
        logic [DW-1:0] data;
    } frame_fields_t;

    function automatic frame_fields_t decode_frame(input logic [WIDTH-1:0] frame);
        frame_fields_t f;
        f.cmd  = frame[CMD_LSB  +: 4];
        f.addr = frame[ADDR_LSB +: 4];
        f.data = frame[DATA_LSB +: DW];
        return f;
    endfunction

    function automatic logic [WIDTH-1:0] build_frame(input logic [3:0]    cmd,
                                                     input logic [3:0]    addr,
                                                     input logic [DW-1:0] data);
        return {FRAME_HDR, cmd, addr, data, FRAME_TRL};
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : spi_sync_edge
//  Description : Two-flop synchronizer for one asynchronous input followed by
//                a registered level and registered rise/fall pulses. Level and
//                pulses are aligned: a pulse cycle already shows the new level.
//  Ports       : clk      - sampling clock
//                rst      - synchronous active-high reset
//                i_async  - asynchronous input pin
//                o_level  - synchronized, registered level
//                o_rise   - 1-cycle pulse on a 0->1 transition
//                o_fall   - 1-cycle pulse on a 1->0 transition
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_level;
    logic r_rise;
    logic r_fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta  <= 1'b0;
            r_sync  <= 1'b0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_meta  <= i_async;
            r_sync  <= r_meta;
            r_level <= r_sync;
            // Pulses are computed from the same compare that updates r_level,
            // so they coincide with the level change.
            r_rise  <= r_sync & ~r_level;
            r_fall  <= ~r_sync & r_level;
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule
`default_nettype wire

// File: rtl/dac_spi_responder.sv
`default_nettype none
// ============================================================================
//  Module      : dac_spi_responder
//  Description : SPI responder for the 32-bit DAC frame. Oversamples SCK, CS
//                and MOSI in the CLK50MHZ domain, shifts frames in MSB first,
//                decodes them into NCH input/output channel registers and
//                returns the previously accepted frame on DAC_OUT.
//  Ports       : CLK50MHZ    - system clock (only clock)
//                RST         - synchronous active-high reset
//                SPI_SCK     - serial clock from master (asynchronous)
//                DAC_CS      - chip select, active low
//                SPI_MOSI    - serial data from master
//                DAC_CLR     - clear, active low, synchronized
//                DAC_OUT     - serial data to master
//                dac_value   - output registers, ch0 in [DW-1:0]
//                frame_word  - last complete frame received
//                frame_valid - 1-cycle pulse: frame accepted
//                frame_error - 1-cycle pulse: CS released with bad bit count
//  Revision    : 1.0 - initial release
// ============================================================================
module dac_spi_responder #(
    parameter int WIDTH = dac_pkg::WIDTH,
    parameter int DW    = dac_pkg::DW,
    parameter int NCH   = dac_pkg::NCH
) (
    input  logic              CLK50MHZ,
    input  logic              RST,
    input  logic              SPI_SCK,
    input  logic              DAC_CS,
    input  logic              SPI_MOSI,
    input  logic              DAC_CLR,
    output logic              DAC_OUT,
    output logic [NCH*DW-1:0] dac_value,
    output logic [WIDTH-1:0]  frame_word,
    output logic              frame_valid,
    output logic              frame_error
);

    import dac_pkg::*;

    localparam int         c_n_in       = 4;
    localparam int         c_idx_sck    = 0;
    localparam int         c_idx_cs     = 1;
    localparam int         c_idx_mosi   = 2;
    localparam int         c_idx_clr    = 3;
    localparam logic [5:0] c_frame_bits = 6'(WIDTH);
    localparam logic [5:0] c_cnt_max    = 6'd63;

    // ------------------------------------------------------------------
    // Input synchronization
    // ------------------------------------------------------------------
    logic [c_n_in-1:0] w_pins;
    logic [c_n_in-1:0] w_level;
    logic [c_n_in-1:0] w_rise;
    logic [c_n_in-1:0] w_fall;

    assign w_pins = {DAC_CLR, SPI_MOSI, DAC_CS, SPI_SCK};

    generate
        for (genvar gi = 0; gi < c_n_in; gi++) begin : g_sync
            spi_sync_edge u_sync (
                .clk     (CLK50MHZ),
                .rst     (RST),
                .i_async (w_pins[gi]),
                .o_level (w_level[gi]),
                .o_rise  (w_rise[gi]),
                .o_fall  (w_fall[gi])
            );
        end
    endgenerate

    logic w_sck_rise;
    logic w_sck_fall;
    logic w_cs_level;
    logic w_cs_rise;
    logic w_cs_fall;
    logic w_mosi;
    logic w_clr_n;
    logic [4:0] w_unused_sync;

    assign w_sck_rise    = w_rise[c_idx_sck];
    assign w_sck_fall    = w_fall[c_idx_sck];
    assign w_cs_level    = w_level[c_idx_cs];
    assign w_cs_rise     = w_rise[c_idx_cs];
    assign w_cs_fall     = w_fall[c_idx_cs];
    assign w_mosi        = w_level[c_idx_mosi];
    assign w_clr_n       = w_level[c_idx_clr];
    assign w_unused_sync = {w_level[c_idx_sck], w_rise[c_idx_mosi], w_fall[c_idx_mosi],
                            w_rise[c_idx_clr], w_fall[c_idx_clr]};

    // ------------------------------------------------------------------
    // Shift path
    // ------------------------------------------------------------------
    logic [5:0]       r_bit_cnt;
    logic [WIDTH-1:0] r_rx_shift;
    logic [WIDTH-1:0] r_tx_shift;
    logic [WIDTH-1:0] r_frame_word;
    logic             r_in_frame;
    logic             r_dac_out;
    logic             r_frame_valid;
    logic             r_frame_error;
    logic             w_frame_ok;

    // r_in_frame is set only by a synchronized CS fall. It keeps SCK edges
    // and the CS rise produced by the synchronizer coming out of reset (or
    // by a frame cut short by reset) from being treated as frame activity.
    assign w_frame_ok = w_cs_rise & r_in_frame & (r_bit_cnt == c_frame_bits);

    always_ff @(posedge CLK50MHZ) begin
        if (RST) begin
            r_bit_cnt     <= '0;
            r_rx_shift    <= '0;
            r_tx_shift    <= '0;
            r_frame_word  <= '0;
            r_in_frame    <= 1'b0;
            r_dac_out     <= 1'b0;
            r_frame_valid <= 1'b0;
            r_frame_error <= 1'b0;
        end else begin
            r_frame_valid <= 1'b0;
            r_frame_error <= 1'b0;
            if (w_cs_fall) begin
                r_in_frame <= 1'b1;
                r_bit_cnt  <= '0;
                r_tx_shift <= r_frame_word;
                r_dac_out  <= r_frame_word[WIDTH-1];
            end else if (w_cs_rise) begin
                r_in_frame <= 1'b0;
                r_dac_out  <= 1'b0;
                if (w_frame_ok) begin
                    r_frame_word  <= r_rx_shift;
                    r_frame_valid <= 1'b1;
                end else if (r_in_frame) begin
                    r_frame_error <= 1'b1;
                end
            end else if (w_cs_level) begin
                r_dac_out <= 1'b0;
            end else if (r_in_frame) begin
                if (w_sck_rise) begin
                    r_rx_shift <= {r_rx_shift[WIDTH-2:0], w_mosi};
                    if (r_bit_cnt != c_cnt_max) begin
                        r_bit_cnt <= r_bit_cnt + 6'd1;
                    end
                end
                // Zeros shift in behind the frame, so DAC_OUT settles to 0
                // once all WIDTH bits have been presented.
                if (w_sck_fall) begin
                    r_tx_shift <= {r_tx_shift[WIDTH-2:0], 1'b0};
                    r_dac_out  <= r_tx_shift[WIDTH-2];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Decode and register file
    // ------------------------------------------------------------------
    frame_fields_t  w_fields;
    logic           w_addr_valid;
    logic [DW-1:0]  w_inreg_nxt [NCH];
    logic [DW-1:0]  w_dac_nxt   [NCH];
    logic [DW-1:0]  r_inreg     [NCH];
    logic [DW-1:0]  r_dac       [NCH];

    assign w_fields     = decode_frame(r_rx_shift);
    assign w_addr_valid = (w_fields.addr == ADDR_ALL) || (w_fields.addr < 4'(NCH));

    always_comb begin
        for (int ch = 0; ch < NCH; ch++) begin
            w_inreg_nxt[ch] = r_inreg[ch];
            w_dac_nxt[ch]   = r_dac[ch];
        end
        if (w_frame_ok) begin
            for (int ch = 0; ch < NCH; ch++) begin
                if (w_fields.addr == ADDR_ALL || w_fields.addr == 4'(ch)) begin
                    case (w_fields.cmd)
                        CMD_WR, CMD_WR_UPDALL: w_inreg_nxt[ch] = w_fields.data;
                        CMD_UPD:               w_dac_nxt[ch]   = r_inreg[ch];
                        CMD_WR_UPD: begin
                            w_inreg_nxt[ch] = w_fields.data;
                            w_dac_nxt[ch]   = w_fields.data;
                        end
                        default: ;
                    endcase
                end
            end
            // Update-all copies the input registers after this frame's write.
            if (w_fields.cmd == CMD_WR_UPDALL && w_addr_valid) begin
                for (int ch = 0; ch < NCH; ch++) begin
                    w_dac_nxt[ch] = w_inreg_nxt[ch];
                end
            end
        end
    end

    always_ff @(posedge CLK50MHZ) begin
        if (RST || !w_clr_n) begin
            for (int ch = 0; ch < NCH; ch++) begin
                r_inreg[ch] <= '0;
                r_dac[ch]   <= '0;
            end
        end else begin
            for (int ch = 0; ch < NCH; ch++) begin
                r_inreg[ch] <= w_inreg_nxt[ch];
                r_dac[ch]   <= w_dac_nxt[ch];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    generate
        for (genvar gc = 0; gc < NCH; gc++) begin : g_pack
            assign dac_value[gc*DW +: DW] = r_dac[gc];
        end
    endgenerate

    assign DAC_OUT     = r_dac_out;
    assign frame_word  = r_frame_word;
    assign frame_valid = r_frame_valid;
    assign frame_error = r_frame_error;

endmodule
`default_nettype wire

// File: tb/tb_dac_spi_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dac_spi_responder
//  Description : Self-checking bench for dac_spi_responder. A bit-banging
//                master drives frames; a channel-level model predicts the
//                registers and pulses, compared on every clock cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dac_spi_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        sck;
    logic        cs;
    logic        mosi;
    logic        clr;
    logic        dout;
    logic [47:0] dac_value;
    logic [31:0] frame_word;
    logic        fv;
    logic        fe;

    always #10 clk = ~clk;

    dac_spi_responder dut (
        .CLK50MHZ    (clk),
        .RST         (rst),
        .SPI_SCK     (sck),
        .DAC_CS      (cs),
        .SPI_MOSI    (mosi),
        .DAC_CLR     (clr),
        .DAC_OUT     (dout),
        .dac_value   (dac_value),
        .frame_word  (frame_word),
        .frame_valid (fv),
        .frame_error (fe)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int cs_hi_run = 0;
    int n_err_seen = 0;

    // Channel-level model
    logic [11:0] m_in  [4];
    logic [11:0] m_dac [4];
    logic [31:0] m_fw;

    // Scheduled effects: kind 0 = good frame, 1 = bad frame, 2 = clear
    typedef struct {
        int          at;
        int          kind;
        logic [31:0] w;
    } ev_t;
    ev_t evq[$];

    function automatic logic [31:0] mk(input logic [3:0] c, input logic [3:0] a,
                                       input logic [11:0] d);
        return {8'h80, c, a, d, 4'h1};
    endfunction

    function automatic logic [47:0] m_pack();
        return {m_dac[3], m_dac[2], m_dac[1], m_dac[0]};
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic model_zero();
        for (int i = 0; i < 4; i++) begin
            m_in[i]  = 12'h000;
            m_dac[i] = 12'h000;
        end
        m_fw = 32'h0;
    endtask

    // Apply a frame's meaning to the model channels.
    task automatic model_frame(input logic [31:0] w);
        logic [3:0]  c;
        logic [3:0]  a;
        logic [11:0] d;
        c = w[23:20];
        a = w[19:16];
        d = w[15:4];
        m_fw = w;
        for (int ch = 0; ch < 4; ch++) begin
            if (a == 4'hF || a == ch[3:0]) begin
                if (c == 4'h0 || c == 4'h2) m_in[ch] = d;
                if (c == 4'h1) m_dac[ch] = m_in[ch];
                if (c == 4'h3) begin
                    m_in[ch]  = d;
                    m_dac[ch] = d;
                end
            end
        end
        if (c == 4'h2 && (a == 4'hF || a < 4'd4)) begin
            for (int ch = 0; ch < 4; ch++) m_dac[ch] = m_in[ch];
        end
    endtask

    // Per-cycle comparison, 1 time unit after the active edge.
    always @(posedge clk) begin
        logic exp_v;
        logic exp_e;
        cyc++;
        cs_hi_run = cs ? cs_hi_run + 1 : 0;
        #1;
        exp_v = 1'b0;
        exp_e = 1'b0;
        for (int i = 0; i < evq.size(); ) begin
            if (evq[i].at == cyc && evq[i].kind != 2) begin
                if (evq[i].kind == 0) begin
                    model_frame(evq[i].w);
                    exp_v = 1'b1;
                end else begin
                    exp_e = 1'b1;
                end
                evq.delete(i);
            end else begin
                i++;
            end
        end
        // Clear wins over a frame landing in the same cycle.
        for (int i = 0; i < evq.size(); ) begin
            if (evq[i].at == cyc && evq[i].kind == 2) begin
                for (int ch = 0; ch < 4; ch++) begin
                    m_in[ch]  = 12'h000;
                    m_dac[ch] = 12'h000;
                end
                evq.delete(i);
            end else begin
                i++;
            end
        end
        chk("dac_value",   {16'h0, dac_value}, {16'h0, m_pack()});
        chk("frame_word",  {32'h0, frame_word}, {32'h0, m_fw});
        chk("frame_valid", {63'h0, fv}, {63'h0, exp_v});
        chk("frame_error", {63'h0, fe}, {63'h0, exp_e});
        if (cs_hi_run >= 5) chk("dac_out_idle", {63'h0, dout}, 64'h0);
        if (fe === 1'b1) n_err_seen++;
    end

    // Bit-banged master. half = SCK half period in clk cycles.
    task automatic send(input logic [31:0] w, input int nbits, input int half,
                        input bit rise_cs, output logic [31:0] miso);
        miso = 32'h0;
        @(negedge clk);
        cs  = 1'b0;
        sck = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            mosi = w[31-i];
            repeat (half) @(negedge clk);
            miso[31-i] = dout;
            sck = 1'b1;
            repeat (half) @(negedge clk);
            sck = 1'b0;
        end
        mosi = 1'b0;
        if (rise_cs) begin
            repeat (half) @(negedge clk);
            cs = 1'b1;
            evq.push_back('{cyc + 4, (nbits == 32) ? 0 : 1, w});
            repeat (10) @(negedge clk);
        end
    endtask

    // Full frame with readback check against the model's previous frame.
    task automatic send_chk(input logic [31:0] w, input int half);
        logic [31:0] miso;
        logic [31:0] prev;
        prev = m_fw;
        send(w, 32, half, 1'b1, miso);
        if (half >= 8) chk("miso_readback", {32'h0, miso}, {32'h0, prev});
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] miso;
        rst  = 1'b1;
        cs   = 1'b1;
        sck  = 1'b0;
        mosi = 1'b0;
        clr  = 1'b1;
        model_zero();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);

        // Reset state
        chk("reset_dac_value",  {16'h0, dac_value}, 64'h0);
        chk("reset_frame_word", {32'h0, frame_word}, 64'h0);
        chk("reset_dac_out",    {63'h0, dout}, 64'h0);

        // 1: write+update ch0
        send_chk(mk(4'h3, 4'h0, 12'hABC), 8);
        chk("t1_dac", {16'h0, dac_value}, 64'h0000_0000_0000_0ABC);

        // 2: write ch2, then update ch2
        send_chk(mk(4'h0, 4'h2, 12'h123), 8);
        chk("t2_after_wr", {16'h0, dac_value}, 64'h0000_0000_0000_0ABC);
        send_chk(mk(4'h1, 4'h2, 12'h000), 8);
        chk("t2_after_upd", {16'h0, dac_value}, 64'h0000_0001_2300_0ABC);

        // 3: readback of the previous frame
        send_chk(32'h8030_5551, 8);
        send(mk(4'hF, 4'h0, 12'h000), 32, 8, 1'b1, miso);
        chk("t3_miso", {32'h0, miso}, 64'h0000_0000_8030_5551);
        chk("t3_frame_word", {32'h0, frame_word}, 64'h0000_0000_80F0_0001);

        // 4: short frame
        send(mk(4'h3, 4'h3, 12'hFFF), 20, 8, 1'b1, miso);
        chk("t4_err_pulses", 64'(n_err_seen), 64'd1);
        chk("t4_dac", {16'h0, dac_value}, 64'h0000_0001_2300_0555);
        chk("t4_frame_word", {32'h0, frame_word}, 64'h0000_0000_80F0_0001);

        // 5: broadcast write+update, then clear
        send_chk(mk(4'h3, 4'hF, 12'hFFF), 8);
        chk("t5_all_fff", {16'h0, dac_value}, 64'h0000_FFFF_FFFF_FFFF);
        @(negedge clk);
        clr = 1'b0;
        evq.push_back('{cyc + 4, 2, 32'h0});
        @(negedge clk);
        clr = 1'b1;
        repeat (8) @(negedge clk);
        chk("t5_cleared", {16'h0, dac_value}, 64'h0);
        chk("t5_frame_word", {32'h0, frame_word}, 64'h0000_0000_803F_FFF1);

        // 6: reset in the middle of a frame, stray SCK, then a clean frame
        send(mk(4'h3, 4'h2, 12'h0AA), 16, 8, 1'b0, miso);
        rst = 1'b1;
        model_zero();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mosi = 1'b1;
            repeat (8) @(negedge clk);
            sck = 1'b1;
            repeat (8) @(negedge clk);
            sck = 1'b0;
        end
        mosi = 1'b0;
        cs = 1'b1;
        repeat (10) @(negedge clk);
        send(mk(4'h3, 4'h1, 12'h7E0), 32, 8, 1'b1, miso);
        chk("t6_miso_after_reset", {32'h0, miso}, 64'h0);
        chk("t6_dac", {16'h0, dac_value}, 64'h0000_0000_007E_0000);
        chk("t6_err_pulses", 64'(n_err_seen), 64'd1);

        // Fast SCK (CLK50MHZ/4)
        send_chk(mk(4'h2, 4'hF, 12'h5A5), 2);
        chk("f1_updall", {16'h0, dac_value}, 64'h0000_5A55_A55A_55A5);
        send_chk(mk(4'h0, 4'h1, 12'h111), 2);
        send_chk(mk(4'h1, 4'hF, 12'h000), 2);
        chk("f3_upd_all", {16'h0, dac_value}, 64'h0000_5A55_A511_15A5);
        send_chk(mk(4'h3, 4'h6, 12'hFFF), 2);
        send_chk(mk(4'h7, 4'h0, 12'hFFF), 2);
        chk("f5_frame_word", {32'h0, frame_word}, 64'h0000_0000_8070_FFF1);
        send_chk(mk(4'h2, 4'h9, 12'h000), 2);
        chk("f6_bad_addr", {16'h0, dac_value}, 64'h0000_5A55_A511_15A5);
        send_chk(mk(4'h2, 4'h0, 12'h321), 2);
        chk("f7_updall_ch0", {16'h0, dac_value}, 64'h0000_5A55_A511_1321);

        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
